// File: rtl/signed_div_8by4.sv
// Sequential signed divider, 8-bit dividend by 4-bit divisor.
// It uses a restoring shift/subtract loop on magnitudes, then one sign-fix cycle.
module signed_div_8by4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] dividend_i,
    input  logic [3:0] divisor_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] quotient_o,
    output logic [3:0] remainder_o,
    output logic       div_by_zero_o,
    output logic       overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] dvdMag_q, dvdMag_d;
    logic [3:0] dvsMag_q, dvsMag_d;
    logic [3:0] prem_q, prem_d;
    logic [7:0] quo_q, quo_d;
    logic       dvdNeg_q, dvdNeg_d;
    logic       dvsNeg_q, dvsNeg_d;
    logic       divZero_q, divZero_d;
    logic       ovf_q, ovf_d;
    logic [7:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       divByZero_q, divByZero_d;
    logic       overflow_q, overflow_d;

    logic       accept;
    logic [7:0] dvdAbs;
    logic [3:0] dvsAbs;
    logic [4:0] trial;
    logic       fits;
    logic [3:0] diff;
    logic [7:0] quoFix;
    logic [3:0] remFix;

    // An unsigned 8-bit magnitude holds 128 exactly, so -128 needs no special path.
    assign dvdAbs = dividend_i[7] ? (8'd0 - dividend_i) : dividend_i;
    assign dvsAbs = divisor_i[3]  ? (4'd0 - divisor_i)  : divisor_i;

    assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    assign trial  = {prem_q, dvdMag_q[7]};
    assign fits   = (trial >= {1'b0, dvsMag_q});
    assign diff   = trial[3:0] - dvsMag_q;

    assign quoFix = (dvdNeg_q ^ dvsNeg_q) ? (8'd0 - quo_q) : quo_q;
    assign remFix = dvdNeg_q ? (4'd0 - prem_q) : prem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            dvdMag_q    <= 8'd0;
            dvsMag_q    <= 4'd0;
            prem_q      <= 4'd0;
            quo_q       <= 8'd0;
            dvdNeg_q    <= 1'b0;
            dvsNeg_q    <= 1'b0;
            divZero_q   <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= 8'd0;
            remainder_q <= 4'd0;
            divByZero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvdMag_q    <= dvdMag_d;
            dvsMag_q    <= dvsMag_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvdNeg_q    <= dvdNeg_d;
            dvsNeg_q    <= dvsNeg_d;
            divZero_q   <= divZero_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvdMag_d    = dvdMag_q;
        dvsMag_d    = dvsMag_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvdNeg_d    = dvdNeg_q;
        dvsNeg_d    = dvsNeg_q;
        divZero_d   = divZero_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    dvdMag_d  = dvdAbs;
                    dvsMag_d  = dvsAbs;
                    dvdNeg_d  = dividend_i[7];
                    dvsNeg_d  = divisor_i[3];
                    divZero_d = (divisor_i == 4'd0);
                    ovf_d     = (dividend_i == 8'h80) && (divisor_i == 4'hF);
                    prem_d    = 4'd0;
                    quo_d     = 8'd0;
                    cnt_d     = 4'd0;
                    // Divide by zero still spends one busy cycle before DONE.
                    state_d   = (divisor_i == 4'd0) ? FIX : ITER;
                end else begin
                    state_d   = IDLE;
                end
            end
            ITER: begin
                // Eight restoring steps, then one alignment cycle before FIX.
                if (!cnt_q[3]) begin
                    prem_d   = fits ? diff : trial[3:0];
                    quo_d    = {quo_q[6:0], fits};
                    dvdMag_d = {dvdMag_q[6:0], 1'b0};
                    cnt_d    = cnt_q + 4'd1;
                end else begin
                    state_d  = FIX;
                end
            end
            FIX: begin
                quotient_d  = divZero_q ? 8'd0 : quoFix;
                remainder_d = divZero_q ? 4'd0 : remFix;
                divByZero_d = divZero_q;
                overflow_d  = ovf_q && !divZero_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q == ITER) || (state_q == FIX);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = divByZero_q;
    assign overflow_o    = overflow_q;

endmodule
